// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: Simple-MIPS fetch-stage controller.
// Owns the PC and sequences fetches from instruction memory. It holds one
// registered instruction for decode while decode stalls. Exceptions and branch
// redirects flush the output slot and retarget the PC in any state.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        BLOCK = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] r_fetch_cnt;

    logic        w_req;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_complete;
    logic        w_slot_free;
    logic        w_slot_blocked;

    // The request drops in the same cycle that a held instruction meets a stall.
    // Then no fetch can complete into an occupied slot.
    always_comb begin
        w_slot_blocked = r_inst_valid && stall_i;
        w_slot_free    = !w_slot_blocked;
        w_req          = (r_state == RUN) && !w_slot_blocked;
        w_redirect     = exc_i || br_taken_i;
        w_redirect_pc  = exc_i ? EXC_VECTOR : (br_target_i & 32'hFFFF_FFFC);
        w_complete     = w_req && imem_rvalid_i && !w_redirect;
    end

    // PC, fetch FSM, output slot and delivery counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_fetch_cnt  <= 32'h0;
        end else if (w_redirect) begin
            // A redirect abandons any in-flight fetch and discards a same-cycle rvalid.
            r_pc         <= w_redirect_pc;
            r_inst_valid <= 1'b0;
            r_state      <= RUN;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_complete) begin
                        r_inst       <= imem_rdata_i;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= r_pc + 32'd4;
                        r_fetch_cnt  <= r_fetch_cnt + 32'd1;
                    end else if (w_slot_free) begin
                        r_inst_valid <= 1'b0;
                    end
                    if (w_slot_blocked)
                        r_state <= BLOCK;
                end
                BLOCK: begin
                    // Decode consumes the held instruction on the cycle stall drops.
                    if (!stall_i) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= RUN;
                    end
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_pc;
    assign inst_valid_o = r_inst_valid;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign fetch_cnt_o  = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed table-driven bench for if_fetch_ctrl.
// The memory model returns the fetch address as the data word.
// Each row gives the inputs for one cycle and the outputs expected during that cycle, before its edge.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = 32'h0;
    logic        exc_i = 1'b0;
    logic        imem_rvalid_i = 1'b1;
    logic [31:0] imem_rdata_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] fetch_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        exc;
        logic        rv;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign imem_rdata_i = imem_addr_o;

    if_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .exc_i        (exc_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic e,
                       input logic r, input logic v, input logic [31:0] p, input logic [31:0] c,
                       input logic q, input logic [31:0] a);
        vec_t x;
        x = '{s, b, t, e, r, v, p, c, q, a};
        vecs.push_back(x);
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] ins, input logic [31:0] c, input logic q,
                           input logic [31:0] a);
        chk({tag, ".valid"}, {31'h0, inst_valid_o}, {31'h0, v});
        chk({tag, ".inst_pc"}, inst_pc_o, p);
        chk({tag, ".inst"}, inst_o, ins);
        chk({tag, ".cnt"}, fetch_cnt_o, c);
        chk({tag, ".req"}, {31'h0, imem_req_o}, {31'h0, q});
        chk({tag, ".addr"}, imem_addr_o, a);
    endtask

    initial begin
        //   stall br tgt          exc rv | valid inst_pc      cnt  req addr
        add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   0, 32'h0);        // 0 BOOT
        add(0, 0, 32'h0,        0, 1,   0, 32'h0,        0,   1, 32'h0);        // 1 fetch 0
        add(0, 0, 32'h0,        0, 1,   1, 32'h0,        1,   1, 32'h4);
        add(0, 0, 32'h0,        0, 1,   1, 32'h4,        2,   1, 32'h8);
        add(1, 0, 32'h0,        0, 1,   1, 32'h8,        3,   0, 32'hC);        // 4 stall x3
        add(1, 0, 32'h0,        0, 1,   1, 32'h8,        3,   0, 32'hC);
        add(1, 0, 32'h0,        0, 1,   1, 32'h8,        3,   0, 32'hC);
        add(0, 0, 32'h0,        0, 1,   1, 32'h8,        3,   0, 32'hC);        // 7 release
        add(0, 0, 32'h0,        0, 1,   0, 32'h8,        3,   1, 32'hC);
        add(0, 0, 32'h0,        0, 0,   1, 32'hC,        4,   1, 32'h10);       // 9 wait
        add(0, 0, 32'h0,        0, 0,   0, 32'hC,        4,   1, 32'h10);       // 10 wait
        add(0, 1, 32'h1003,     0, 1,   0, 32'hC,        4,   1, 32'h10);       // 11 branch
        add(0, 0, 32'h0,        0, 1,   0, 32'hC,        4,   1, 32'h1000);
        add(0, 1, 32'h400,      1, 1,   1, 32'h1000,     5,   1, 32'h1004);     // 13 exc+br
        add(0, 0, 32'h0,        0, 1,   0, 32'h1000,     5,   1, 32'h20);
        add(0, 0, 32'h0,        0, 1,   1, 32'h20,       6,   1, 32'h24);
        add(0, 0, 32'h0,        0, 1,   1, 32'h24,       7,   1, 32'h28);
        add(0, 0, 32'h0,        0, 1,   1, 32'h28,       8,   1, 32'h2C);
        add(0, 0, 32'h0,        0, 1,   1, 32'h2C,       9,   1, 32'h30);
        add(1, 0, 32'h0,        0, 1,   1, 32'h30,       10,  0, 32'h34);       // 19 stall on 0x30
        add(1, 1, 32'h200,      0, 1,   1, 32'h30,       10,  0, 32'h34);       // 20 br in stall
        add(1, 0, 32'h0,        0, 0,   0, 32'h30,       10,  1, 32'h200);
        add(0, 0, 32'h0,        0, 1,   0, 32'h30,       10,  1, 32'h200);
        add(0, 1, 32'hFFFF_FFFE,0, 1,   1, 32'h200,      11,  1, 32'h204);      // 23 br to top
        add(0, 0, 32'h0,        0, 1,   0, 32'h200,      11,  1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,        0, 1,   1, 32'hFFFF_FFFC,12,  1, 32'h0);        // wrap
        add(0, 0, 32'h0,        0, 0,   1, 32'h0,        13,  1, 32'h4);
        add(0, 0, 32'h0,        0, 0,   0, 32'h0,        13,  1, 32'h4);        // 27 mid-wait

        // Reset state while rst is held
        @(negedge clk);
        @(negedge clk);
        #1 chk_all("reset", 0, 32'h0, 32'h0, 0, 0, 32'h0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b0;
            stall_i       = vecs[k].stall;
            br_taken_i    = vecs[k].br;
            br_target_i   = vecs[k].tgt;
            exc_i         = vecs[k].exc;
            imem_rvalid_i = vecs[k].rv;
            #1 chk_all($sformatf("row%0d", k), vecs[k].e_valid, vecs[k].e_pc, vecs[k].e_pc,
                       vecs[k].e_cnt, vecs[k].e_req, vecs[k].e_addr);
        end

        // Async reset mid-wait, checked before any clock edge
        @(negedge clk);
        #3 rst = 1'b1;
        #1 chk_all("async_rst", 0, 32'h0, 32'h0, 0, 0, 32'h0);

        // Branch during BOOT still moves to RUN at the target
        @(negedge clk);
        rst = 1'b0;
        stall_i = 1'b0; exc_i = 1'b0; imem_rvalid_i = 1'b1;
        br_taken_i = 1'b1; br_target_i = 32'h80;
        #1 chk_all("boot_br", 0, 32'h0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        br_taken_i = 1'b0;
        #1 chk_all("boot_br_run", 0, 32'h0, 32'h0, 0, 1, 32'h80);
        @(negedge clk);
        #1 chk_all("boot_br_inst", 1, 32'h80, 32'h80, 1, 1, 32'h84);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch-stage controller for the Simple-MIPS front end. It owns the program counter and sequences instruction fetch from instruction memory. It selects each next PC from sequential (+4), branch redirect or exception vector, and presents one registered instruction per cycle to decode, holding it while decode stalls. It sits between the instruction-memory port and the IF/ID boundary, and replaces free-running PC increment with stall- and flush-aware sequencing.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- EXC_VECTOR, 32'h0000_0020, PC loaded on exception.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  decode cannot accept; the held instruction must stay unchanged.
- br_taken_i  in  1  branch redirect request (single-cycle pulse).
- br_target_i  in  32  redirect target; bits [1:0] ignored (treated as 0).
- exc_i  in  1  exception redirect to EXC_VECTOR (pulse).
- imem_rvalid_i  in  1  imem_rdata_i is valid for the current imem_addr_o this cycle.
- imem_rdata_i  in  32  instruction word.
- imem_req_o  out  1  fetch request; address valid while high.
- imem_addr_o  out  32  fetch address, always word aligned.
- inst_valid_o  out  1  inst_o/inst_pc_o hold a valid instruction for decode.
- inst_o  out  32  fetched instruction.
- inst_pc_o  out  32  PC of inst_o.
- fetch_cnt_o  out  32  count of instructions delivered to decode; wraps modulo 2^32.

## Operation
- State: pc_q (32 bits), FSM {BOOT, RUN, BLOCK}, output register, counter.
- Reset (asynchronous): pc_q=RESET_PC, FSM=BOOT, imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, fetch_cnt_o=0.
- imem_addr_o = pc_q at all times. imem_req_o = 1 only in RUN.
- BOOT: one cycle with no request, then go to RUN. A redirect in BOOT loads pc_q and still goes to RUN.
- Completion: a cycle with imem_req_o && imem_rvalid_i and no redirect. On completion:
  - inst_o <= rdata, inst_pc_o <= pc_q, inst_valid_o <= 1.
  - pc_q <= pc_q + 4 (wraps 0xFFFF_FFFC -> 0).
  - fetch_cnt_o increments.
- Output slot: free when inst_valid_o==0 or stall_i==0. When free and there is no completion, inst_valid_o <= 0.
- RUN -> BLOCK: stall_i==1 and inst_valid_o==1 (slot occupied). No request is issued in BLOCK, and the output registers hold.
- BLOCK -> RUN: stall_i==0. In that cycle decode consumes the held instruction and inst_valid_o <= 0.
- In RUN a completion only occurs when the slot is free. imem_req_o is forced low the same cycle the slot is blocked, i.e. imem_req_o = RUN && !(inst_valid_o && stall_i).
- Redirect priority: exc_i > br_taken_i > normal sequencing. Redirects are honoured in every state, regardless of stall_i. On redirect:
  - pc_q <= EXC_VECTOR or {br_target_i[31:2],2'b00}.
  - inst_valid_o <= 0 (flush).
  - Any same-cycle rvalid is discarded and not counted.
  - FSM -> RUN, unless in BOOT (still -> RUN).
- Memory wait states: while rvalid_i==0, imem_req_o and imem_addr_o stay stable. A redirect during a wait abandons the fetch; the address changes next cycle.

## Timing
- Zero-wait memory (rvalid_i tied high): one instruction per cycle. RESET_PC appears on inst_o in the 2nd cycle after rst deasserts (BOOT, then fetch).
- Fetch-to-decode latency is 1 cycle: completion at cycle t gives inst_valid_o=1 at t+1.
- Redirect at cycle t: imem_addr_o=target at t+1, inst_valid_o=0 at t+1, first target instruction valid at t+2 (zero-wait).
- Stall: inst_o/inst_pc_o remain constant for every cycle stall_i==1 with inst_valid_o==1. No PC advance.
- rst asserted mid-fetch or mid-stall clears everything immediately, with no clock edge needed.

## Test plan
- Reset/boot: deassert rst, zero-wait memory returning addr as data -> inst_pc_o sequence 0x0, 0x4, 0x8 on consecutive cycles starting the 2nd cycle; fetch_cnt_o = 1, 2, 3.
- Stall hold: raise stall_i for 3 cycles while inst_pc_o=0x8 -> imem_req_o=0, inst_o/inst_pc_o frozen at 0x8, fetch_cnt_o frozen. After release, 0xC follows one cycle later.
- Branch with wait states: rvalid_i low for 2 cycles at 0x10, br_taken_i pulse with target 0x1003 -> next imem_addr_o=0x1000, inst_valid_o=0 for 1 cycle, then inst_pc_o=0x1000; stale 0x10 never delivered.
- Exception vs branch: exc_i and br_taken_i in the same cycle (target 0x400) -> pc_q=0x20; a same-cycle rvalid is not counted.
- Redirect during stall: stall_i=1 with held 0x30, then br_taken_i to 0x200 -> inst_valid_o drops next cycle; fetch of 0x200 proceeds once stall_i=0.
- Wrap/async reset: start pc at 0xFFFF_FFFC via branch -> next inst_pc_o=0x0. Assert rst mid-wait -> all outputs return to reset values before the next edge.
